// File: rtl/regfile_wr_arb_pkg.sv
// Shared definitions for the register-file write-port arbiter and its round-robin grant helper.
package regfile_wr_arb_pkg;

  localparam int unsigned AW_DEF = 4;
  localparam int unsigned DW_DEF = 8;
  localparam int unsigned CNT_W  = 8;

  // Grant encoding doubles as the bit index into the two-bit request/grant vectors.
  typedef enum logic {
    GRANT_CORE = 1'b0,
    GRANT_DBG  = 1'b1
  } grant_e;

  localparam logic [AW_DEF-1:0] REG_ZERO = '0;

endpackage

// File: rtl/regfile_wr_arb_rr_arb2.sv
// Combinational two-way round-robin grant: a lone requester wins, and on contention
// the side that was not granted last wins.
module rr_arb2
  import regfile_wr_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  grant_e     last_i,
  output logic [1:0] gnt_c_o,
  output grant_e     side_c_o
);

  always_comb begin
    gnt_c_o  = 2'b00;
    side_c_o = last_i;
    unique case (req_i)
      2'b01: begin
        gnt_c_o  = 2'b01;
        side_c_o = GRANT_CORE;
      end
      2'b10: begin
        gnt_c_o  = 2'b10;
        side_c_o = GRANT_DBG;
      end
      2'b11: begin
        if (last_i == GRANT_CORE) begin
          gnt_c_o  = 2'b10;
          side_c_o = GRANT_DBG;
        end else begin
          gnt_c_o  = 2'b01;
          side_c_o = GRANT_CORE;
        end
      end
      default: begin
        gnt_c_o  = 2'b00;
        side_c_o = last_i;
      end
    endcase
  end

endmodule

// File: rtl/regfile_wr_arb.sv
// Shares the 16x8 register file write port between core writeback and debug/loader,
// round-robin on contention, with a registered write stage toward the file.
module regfile_wr_arb
  import regfile_wr_arb_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_paused,
  input  logic             core_valid,
  input  logic [AW-1:0]    core_wa,
  input  logic [DW-1:0]    core_wd,
  output logic             core_ready,
  input  logic             dbg_valid,
  input  logic [AW-1:0]    dbg_wa,
  input  logic [DW-1:0]    dbg_wd,
  output logic             dbg_ready,
  output logic [AW-1:0]    rf_wa,
  output logic [DW-1:0]    rf_wd,
  output logic             rf_we,
  output logic             rf_paused,
  output logic             zero_drop,
  output logic [CNT_W-1:0] dbg_wr_cnt
);

  logic [1:0]       elig_c;
  logic [1:0]       gnt_c;
  grant_e           gnt_side_c;
  logic             xfer_c;
  logic [AW-1:0]    sel_wa_c;
  logic [DW-1:0]    sel_wd_c;
  logic             sel_zero_c;

  grant_e           last_grant_q, last_grant_d;
  logic             rf_we_q, rf_we_d;
  logic [AW-1:0]    rf_wa_q, rf_wa_d;
  logic [DW-1:0]    rf_wd_q, rf_wd_d;
  logic             zero_drop_q, zero_drop_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A halted core is simply not eligible; debug is never blocked.
  assign elig_c = {dbg_valid, core_valid & ~cpu_paused};

  rr_arb2 u_rr_arb2 (
    .req_i    (elig_c),
    .last_i   (last_grant_q),
    .gnt_c_o  (gnt_c),
    .side_c_o (gnt_side_c)
  );

  assign core_ready = gnt_c[0];
  assign dbg_ready  = gnt_c[1];
  assign xfer_c     = |gnt_c;

  assign sel_wa_c   = (gnt_side_c == GRANT_DBG) ? dbg_wa : core_wa;
  assign sel_wd_c   = (gnt_side_c == GRANT_DBG) ? dbg_wd : core_wd;
  assign sel_zero_c = (sel_wa_c == AW'(REG_ZERO));

  always_comb begin
    last_grant_d = last_grant_q;
    rf_we_d      = 1'b0;
    rf_wa_d      = rf_wa_q;
    rf_wd_d      = rf_wd_q;
    zero_drop_d  = 1'b0;
    cnt_d        = cnt_q;
    if (xfer_c) begin
      last_grant_d = gnt_side_c;
      rf_wa_d      = sel_wa_c;
      rf_wd_d      = sel_wd_c;
      rf_we_d      = ~sel_zero_c;
      zero_drop_d  = sel_zero_c;
      if ((gnt_side_c == GRANT_DBG) && !sel_zero_c) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= GRANT_DBG;
      rf_we_q      <= 1'b0;
      rf_wa_q      <= '0;
      rf_wd_q      <= '0;
      zero_drop_q  <= 1'b0;
      cnt_q        <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rf_we_q      <= rf_we_d;
      rf_wa_q      <= rf_wa_d;
      rf_wd_q      <= rf_wd_d;
      zero_drop_q  <= zero_drop_d;
      cnt_q        <= cnt_d;
    end
  end

  // The file is forced unpaused in exactly the cycles a write is presented to it.
  assign rf_paused  = cpu_paused & ~rf_we_q;
  assign rf_we      = rf_we_q;
  assign rf_wa      = rf_wa_q;
  assign rf_wd      = rf_wd_q;
  assign zero_drop  = zero_drop_q;
  assign dbg_wr_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wr_arb.sv
// Scoreboard bench for regfile_wr_arb: directed requests push expected file writes,
// a monitor pops and compares whenever the arbiter presents a write or a register-0 drop.
module tb_regfile_wr_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cpu_paused;
  logic       core_valid;
  logic [3:0] core_wa;
  logic [7:0] core_wd;
  logic       core_ready;
  logic       dbg_valid;
  logic [3:0] dbg_wa;
  logic [7:0] dbg_wd;
  logic       dbg_ready;
  logic [3:0] rf_wa;
  logic [7:0] rf_wd;
  logic       rf_we;
  logic       rf_paused;
  logic       zero_drop;
  logic [7:0] dbg_wr_cnt;

  typedef struct packed {
    logic       we;
    logic       zd;
    logic [3:0] wa;
    logic [7:0] wd;
    logic [7:0] cnt;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_cnt;
  int         checks = 0;
  int         errors = 0;

  regfile_wr_arb #(.AW(4), .DW(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_paused (cpu_paused),
    .core_valid (core_valid),
    .core_wa    (core_wa),
    .core_wd    (core_wd),
    .core_ready (core_ready),
    .dbg_valid  (dbg_valid),
    .dbg_wa     (dbg_wa),
    .dbg_wd     (dbg_wd),
    .dbg_ready  (dbg_ready),
    .rf_wa      (rf_wa),
    .rf_wd      (rf_wd),
    .rf_we      (rf_we),
    .rf_paused  (rf_paused),
    .zero_drop  (zero_drop),
    .dbg_wr_cnt (dbg_wr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [3:0] wa, input logic [7:0] wd, input logic is_dbg);
    exp_t e;
    e.we = (wa != 4'd0);
    e.zd = (wa == 4'd0);
    e.wa = wa;
    e.wd = wd;
    if (is_dbg && wa != 4'd0) model_cnt = model_cnt + 8'd1;
    e.cnt = model_cnt;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of requests at the falling edge and check the expected grants.
  task automatic cycle(input logic cv, input logic [3:0] cwa, input logic [7:0] cwd,
                       input logic dv, input logic [3:0] dwa, input logic [7:0] dwd,
                       input logic pz, input logic ecr, input logic edr);
    @(negedge clk);
    core_valid = cv;  core_wa = cwa; core_wd = cwd;
    dbg_valid  = dv;  dbg_wa  = dwa; dbg_wd  = dwd;
    cpu_paused = pz;
    #1;
    chk("core_ready", core_ready, ecr);
    chk("dbg_ready",  dbg_ready,  edr);
    if (ecr) push_exp(cwa, cwd, 1'b0);
    if (edr) push_exp(dwa, dwd, 1'b1);
  endtask

  task automatic idle(input logic pz);
    cycle(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0, pz, 1'b0, 1'b0);
  endtask

  // Monitor: every presented write or register-0 drop must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && (rf_we || zero_drop)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: we=%0b zd=%0b wa=%0h wd=%0h with nothing expected",
                   rf_we, zero_drop, rf_wa, rf_wd);
        end else begin
          e = exp_q.pop_front();
          chk("mon rf_we",      rf_we,      e.we);
          chk("mon zero_drop",  zero_drop,  e.zd);
          chk("mon rf_wa",      rf_wa,      e.wa);
          chk("mon rf_wd",      rf_wd,      e.wd);
          chk("mon dbg_wr_cnt", dbg_wr_cnt, e.cnt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_cnt  = 8'd0;
    rst_n      = 1'b0;
    cpu_paused = 1'b1;
    core_valid = 1'b0; core_wa = 4'd0; core_wd = 8'd0;
    dbg_valid  = 1'b0; dbg_wa  = 4'd0; dbg_wd  = 8'd0;
    #12;
    chk("rst rf_we",      rf_we,      1'b0);
    chk("rst rf_wa",      rf_wa,      4'd0);
    chk("rst rf_wd",      rf_wd,      8'd0);
    chk("rst zero_drop",  zero_drop,  1'b0);
    chk("rst dbg_wr_cnt", dbg_wr_cnt, 8'd0);
    chk("rst rf_paused",  rf_paused,  1'b1);
    @(negedge clk);
    rst_n      = 1'b1;
    cpu_paused = 1'b0;

    // Contention after reset: C,D,C,D.
    cycle(1'b1, 4'd1, 8'h11, 1'b1, 4'd2, 8'h22, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 4'd1, 8'h11, 1'b1, 4'd2, 8'h22, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 4'd1, 8'h11, 1'b1, 4'd2, 8'h22, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 4'd1, 8'h11, 1'b1, 4'd2, 8'h22, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    chk("contention cnt", dbg_wr_cnt, 8'd2);

    // Single core write.
    cycle(1'b1, 4'd3, 8'hA5, 1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    chk("single rf_we",     rf_we,     1'b1);
    chk("single rf_wa",     rf_wa,     4'd3);
    chk("single rf_wd",     rf_wd,     8'hA5);
    chk("single rf_paused", rf_paused, 1'b0);

    // Paused core: only debug is granted, and its write unpauses the file.
    cycle(1'b1, 4'd1, 8'h77, 1'b1, 4'd5, 8'h3C, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 4'd1, 8'h77, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("paused rf_we",     rf_we,     1'b1);
    chk("paused rf_wa",     rf_wa,     4'd5);
    chk("paused rf_wd",     rf_wd,     8'h3C);
    chk("paused rf_paused", rf_paused, 1'b0);
    cycle(1'b1, 4'd1, 8'h77, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("paused idle rf_paused", rf_paused, 1'b1);
    chk("paused idle rf_we",     rf_we,     1'b0);

    // Register-0 write from debug: accepted, dropped, not counted.
    cycle(1'b0, 4'd0, 8'h00, 1'b1, 4'd0, 8'hFF, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    chk("reg0 rf_we",      rf_we,      1'b0);
    chk("reg0 zero_drop",  zero_drop,  1'b1);
    chk("reg0 dbg_wr_cnt", dbg_wr_cnt, 8'd3);
    cycle(1'b1, 4'd2, 8'h5A, 1'b1, 4'd6, 8'h66, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 4'd0, 8'h00, 1'b1, 4'd6, 8'h66, 1'b0, 1'b0, 1'b1);

    // Reset with a core write in flight.
    cycle(1'b1, 4'd4, 8'h44, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    core_valid = 1'b1; core_wa = 4'd6; core_wd = 8'h66;
    dbg_valid  = 1'b0;
    #1;
    chk("inflight core_ready", core_ready, 1'b1);
    chk("pre-reset rf_we",     rf_we,      1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async rst rf_we",     rf_we,      1'b0);
    chk("async rst rf_wa",     rf_wa,      4'd0);
    chk("async rst cnt",       dbg_wr_cnt, 8'd0);
    chk("async rst zero_drop", zero_drop,  1'b0);
    core_valid = 1'b0;
    exp_q.delete();
    model_cnt = 8'd0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 4'd1, 8'h11, 1'b1, 4'd2, 8'h22, 1'b0, 1'b1, 1'b0);

    // Counter wrap: 256 debug writes to register 7.
    for (int i = 0; i < 256; i++) begin
      cycle(1'b0, 4'd0, 8'd0, 1'b1, 4'd7, 8'(i), 1'b0, 1'b0, 1'b1);
    end
    idle(1'b0);
    chk("wrap last rf_we", rf_we,      1'b1);
    chk("wrap dbg_wr_cnt", dbg_wr_cnt, 8'd0);
    idle(1'b0);
    idle(1'b0);
    chk("queue drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
